// File: rtl/vga_timing_pkg.sv
// Shared types and default mode constants for the VGA timing controller.
// Default mode is 1024x768 @ 70 Hz.
package vga_timing_pkg;

   // Phase of one scan axis, in the order the axis visits them
   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FRONT,
      PH_SYNC,
      PH_BACK
   } vga_phase_t;

   localparam int DEF_H_ACTIVE = 1024;
   localparam int DEF_H_FRONT  = 24;
   localparam int DEF_H_SYNC   = 136;
   localparam int DEF_H_BACK   = 144;

   localparam int DEF_V_ACTIVE = 768;
   localparam int DEF_V_FRONT  = 3;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BACK   = 29;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   // Number of counts in one full pass of an axis
   function automatic int axis_total(input int active, input int front,
                                     input int sync, input int back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_sequencer.sv
// One scan axis: a wrapping position counter with its ACTIVE/FRONT/SYNC/BACK
// phase. The count/phase outputs show the position the axis holds after the
// current edge (equal to the held position when advance=0), so the parent can
// register outputs that line up with the counter without a latency slip.
module vga_axis_sequencer
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FRONT  = DEF_H_FRONT,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BACK   = DEF_H_BACK,
   parameter int WIDTH  = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [WIDTH-1:0] count,
   output vga_phase_t       phase,
   output logic             wrap
);

   localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
   localparam logic [WIDTH-1:0] LAST        = WIDTH'(TOTAL - 1);
   localparam logic [WIDTH-1:0] FRONT_START = WIDTH'(ACTIVE);
   localparam logic [WIDTH-1:0] SYNC_START  = WIDTH'(ACTIVE + FRONT);
   localparam logic [WIDTH-1:0] BACK_START  = WIDTH'(ACTIVE + FRONT + SYNC);
   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   vga_phase_t       phase_q;

   // Range decode; an empty range never matches, so zero-length phases drop out
   function automatic vga_phase_t phase_of(input logic [WIDTH-1:0] c);
      if (c < FRONT_START)     return PH_ACTIVE;
      else if (c < SYNC_START) return PH_FRONT;
      else if (c < BACK_START) return PH_SYNC;
      else                     return PH_BACK;
   endfunction

   // Position/phase state; reset parks on the last count so the next advance lands on 0
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= LAST;
         phase_q <= PH_BACK;
      end else begin
         count_q <= count;
         phase_q <= phase;
      end
   end

   // Next position and phase, wrapping from the last count back to 0
   always_comb begin
      wrap  = 1'b0;
      count = count_q;
      phase = phase_q;
      if (advance) begin
         if (count_q == LAST) begin
            wrap  = 1'b1;
            count = '0;
         end else begin
            count = count_q + ONE;
         end
         phase = phase_of(count);
      end
   end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA timing generator: horizontal and vertical axis sequencers advanced by the
// pixel tick, with all outputs registered on the same edge as the counters.
// Optional macro VGA_TIMING_LINE_START_EN adds a line_start pulse output.
module vga_timing_controller
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FRONT    = DEF_H_FRONT,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BACK     = DEF_H_BACK,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FRONT    = DEF_V_FRONT,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BACK     = DEF_V_BACK,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int H_WIDTH    = 11,
   parameter int V_WIDTH    = 10
) (
   input  logic               control_clock,
   input  logic               reset,
   input  logic               enable,
   output logic               h_sync,
   output logic               v_sync,
   output logic               display_enable,
   output logic [H_WIDTH-1:0] pixel_x,
   output logic [V_WIDTH-1:0] pixel_y,
   output logic               frame_start
`ifdef VGA_TIMING_LINE_START_EN
   ,
   output logic               line_start
`endif
);

   logic [H_WIDTH-1:0] h_count;
   logic [V_WIDTH-1:0] v_count;
   vga_phase_t         h_phase;
   vga_phase_t         v_phase;
   logic               h_wrap;
   logic               v_wrap;
   logic               active;

   vga_axis_sequencer #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK),
      .WIDTH  (H_WIDTH)
   ) u_h_axis (
      .clk     (control_clock),
      .reset   (reset),
      .advance (enable),
      .count   (h_count),
      .phase   (h_phase),
      .wrap    (h_wrap)
   );

   // The vertical axis steps only on the enabled edge where the line wraps
   vga_axis_sequencer #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK),
      .WIDTH  (V_WIDTH)
   ) u_v_axis (
      .clk     (control_clock),
      .reset   (reset),
      .advance (h_wrap),
      .count   (v_count),
      .phase   (v_phase),
      .wrap    (v_wrap)
   );

   // Visible region of the position being entered on this edge
   always_comb begin
      active = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
   end

   // Output register: updates with the counters, holds while enable=0, pulses self-clear
   always_ff @(posedge control_clock) begin
      if (reset) begin
         h_sync         <= ~H_SYNC_POL;
         v_sync         <= ~V_SYNC_POL;
         display_enable <= 1'b0;
         pixel_x        <= '0;
         pixel_y        <= '0;
         frame_start    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (enable) begin
            h_sync         <= (h_phase == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync         <= (v_phase == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            display_enable <= active;
            pixel_x        <= active ? h_count : '0;
            pixel_y        <= active ? v_count : '0;
            frame_start    <= h_wrap && v_wrap;
         end
      end
   end

`ifdef VGA_TIMING_LINE_START_EN
   // Start-of-line pulse on every line, blanking lines included
   always_ff @(posedge control_clock) begin
      if (reset) begin
         line_start <= 1'b0;
      end else begin
         line_start <= enable && h_wrap;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller: a default-mode instance for line
// timing and a shrunken-mode instance (16 x 9 counts) for frame-level timing.
module tb_vga_timing_controller;
   import vga_timing_pkg::*;

   // Shrunken mode: H 8/2/3/3 = 16, V 4/1/2/2 = 9, frame = 144 clocks
   localparam int SH_T = 16;
   localparam int SV_T = 9;
   localparam int SF_T = SH_T * SV_T;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;

   logic        h_sync, v_sync, de, fs;
   logic [10:0] px;
   logic [9:0]  py;
   logic        s_h_sync, s_v_sync, s_de, s_fs;
   logic [3:0]  s_px, s_py;
`ifdef VGA_TIMING_LINE_START_EN
   logic        ls, s_ls;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   int lin, h, ln, n_en;
   int cnt_a, cnt_b, cnt_c, cnt_d, bad;
   int first_a, mark_a, mark_b;
   logic prev;

   always #5 clk = ~clk;

   vga_timing_controller dut (
      .control_clock  (clk),
      .reset          (reset),
      .enable         (enable),
      .h_sync         (h_sync),
      .v_sync         (v_sync),
      .display_enable (de),
      .pixel_x        (px),
      .pixel_y        (py),
      .frame_start    (fs)
`ifdef VGA_TIMING_LINE_START_EN
      ,
      .line_start     (ls)
`endif
   );

   vga_timing_controller #(
      .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
      .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
      .H_WIDTH  (4), .V_WIDTH (4)
   ) dut_s (
      .control_clock  (clk),
      .reset          (reset),
      .enable         (enable),
      .h_sync         (s_h_sync),
      .v_sync         (s_v_sync),
      .display_enable (s_de),
      .pixel_x        (s_px),
      .pixel_y        (s_py),
      .frame_start    (s_fs)
`ifdef VGA_TIMING_LINE_START_EN
      ,
      .line_start     (s_ls)
`endif
   );

   task automatic check(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      reset = 1'b1; enable = 1'b0;
      tick(); tick();
      check("rst_de", int'(de), 0);
      check("rst_hsync", int'(h_sync), 1);
      check("rst_vsync", int'(v_sync), 1);
      check("rst_px", int'(px), 0);
      check("rst_py", int'(py), 0);
      check("rst_fs", int'(fs), 0);
      check("s_rst_de", int'(s_de), 0);

      // First enabled edge lands on (0,0)
      reset = 1'b0; enable = 1'b1;
      tick();
      check("first_px", int'(px), 0);
      check("first_py", int'(py), 0);
      check("first_de", int'(de), 1);
      check("first_fs", int'(fs), 1);
      check("first_hsync", int'(h_sync), 1);
      tick();
      check("second_px", int'(px), 1);
      check("second_fs", int'(fs), 0);
      check("second_de", int'(de), 1);

      // Two default-mode lines, positions 2 .. 2657
      cnt_a = 0; cnt_b = 0; cnt_c = 0; bad = 0;
      first_a = -1; mark_a = -1; mark_b = -1; prev = h_sync;
      for (int i = 0; i < 2 * DEF_H_TOTAL; i++) begin
         tick();
         lin = i + 2;
         h   = lin % DEF_H_TOTAL;
         ln  = lin / DEF_H_TOTAL;
         if (lin >= DEF_H_TOTAL && lin < 2 * DEF_H_TOTAL) begin
            if (de) cnt_a++;
            if (!h_sync) cnt_b++;
         end
         if (!v_sync) cnt_c++;
         if (prev && !h_sync) begin
            if (mark_a < 0) begin
               mark_a = lin;
               first_a = h;
            end else if (mark_b < 0) begin
               mark_b = lin;
            end
         end
         prev = h_sync;
         if (int'(de) != ((h < 1024) ? 1 : 0)) bad++;
         if (int'(px) != ((h < 1024) ? h : 0)) bad++;
         if (int'(py) != ((h < 1024) ? ln : 0)) bad++;
      end
      check("line_de_clocks", cnt_a, 1024);
      check("line_hsync_low", cnt_b, 136);
      check("hsync_first_count", first_a, 1048);
      check("line_period", mark_b - mark_a, DEF_H_TOTAL);
      check("line_pos_errors", bad, 0);
      check("vsync_in_top_lines", cnt_c, 0);

      // Shrunken-mode frames with enable held high
      reset = 1'b1; tick();
      reset = 1'b0; enable = 1'b1;
      cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; bad = 0;
      first_a = -1; mark_a = -1; mark_b = -1;
      for (int k = 1; k <= 2 * SF_T; k++) begin
         tick();
         lin = k - 1;
         h   = lin % SH_T;
         ln  = (lin / SH_T) % SV_T;
         if (s_fs) begin
            cnt_a++;
            if (mark_a < 0) mark_a = k; else if (mark_b < 0) mark_b = k;
         end
         if (lin < SF_T) begin
            if (!s_v_sync) begin
               cnt_b++;
               if (first_a < 0) first_a = lin;
            end
            if (s_de) cnt_c++;
            if (!s_h_sync) cnt_d++;
         end
         if (int'(s_px) != ((h < 8 && ln < 4) ? h : 0)) bad++;
         if (int'(s_py) != ((h < 8 && ln < 4) ? ln : 0)) bad++;
      end
      check("s_fs_pulses", cnt_a, 2);
      check("s_frame_period", mark_b - mark_a, SF_T);
      check("s_vsync_low", cnt_b, 2 * SH_T);
      check("s_vsync_first", first_a, 5 * SH_T);
      check("s_de_clocks", cnt_c, 32);
      check("s_hsync_low", cnt_d, 3 * SV_T);
      check("s_pos_errors", bad, 0);

`ifdef VGA_TIMING_LINE_START_EN
      // Line pulses over one shrunken frame
      reset = 1'b1; tick();
      reset = 1'b0; enable = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int k = 1; k <= SF_T; k++) begin
         tick();
         if (s_ls) cnt_a++;
         if (s_ls && s_fs) cnt_b++;
      end
      check("s_ls_pulses", cnt_a, SV_T);
      check("s_ls_with_fs", cnt_b, 1);
`endif

      // Enable toggling 1,0,1,0: everything stretches by two, pulses stay one clock
      reset = 1'b1; enable = 1'b0; tick();
      reset = 1'b0;
      n_en = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0; bad = 0;
      mark_a = -1; mark_b = -1; prev = 1'b0;
      for (int k = 0; k < 4 * SF_T; k++) begin
         enable = (k % 2 == 0);
         if (enable) n_en++;
         tick();
         lin = n_en - 1;
         h   = lin % SH_T;
         ln  = (lin / SH_T) % SV_T;
         if (s_fs) begin
            cnt_a++;
            if (mark_a < 0) mark_a = k; else if (mark_b < 0) mark_b = k;
         end
         if (s_fs && prev) cnt_c++;
         prev = s_fs;
         if (k < 2 * SF_T && !s_v_sync) cnt_b++;
         if (int'(s_px) != ((h < 8 && ln < 4) ? h : 0)) bad++;
         if (int'(s_de) != ((h < 8 && ln < 4) ? 1 : 0)) bad++;
         if (k == 1) begin
            check("hold_fs_cleared", int'(s_fs), 0);
            check("hold_de", int'(s_de), 1);
         end
      end
      check("tog_fs_pulses", cnt_a, 2);
      check("tog_frame_period", mark_b - mark_a, 2 * SF_T);
      check("tog_fs_wide", cnt_c, 0);
      check("tog_vsync_low", cnt_b, 4 * SH_T);
      check("tog_pos_errors", bad, 0);

      // Reset in the middle of the visible area
      reset = 1'b1; enable = 1'b0; tick();
      reset = 1'b0; enable = 1'b1;
      for (int k = 0; k < 2 * SH_T + 6; k++) tick();
      check("mid_px", int'(s_px), 5);
      check("mid_py", int'(s_py), 2);
      check("mid_de", int'(s_de), 1);
      reset = 1'b1; enable = 1'b1;
      tick();
      check("midrst_de", int'(s_de), 0);
      check("midrst_px", int'(s_px), 0);
      check("midrst_py", int'(s_py), 0);
      check("midrst_hsync", int'(s_h_sync), 1);
      check("midrst_top_px", int'(px), 0);
      reset = 1'b0; enable = 1'b1;
      tick();
      check("restart_px", int'(s_px), 0);
      check("restart_fs", int'(s_fs), 1);
      check("restart_de", int'(s_de), 1);
      check("restart_top_fs", int'(fs), 1);
      tick();
      check("restart_fs_clear", int'(s_fs), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
